// File: rtl/pipe_ctrl_pkg.sv
// Shared control encodings for the D-stage decoder and the ID/EX register.
// Opcodes, ALU/ImmSrc/ResultSrc codes, branch bit indices, control bundle.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RT   = 7'b0110011;
  localparam logic [6:0] OP_BT   = 7'b1100011;
  localparam logic [6:0] OP_IT   = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [6:0] F7_M   = 7'b0000001;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_PASSB = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_MD  = 2'd3;

  localparam int BR_BEQ  = 0;
  localparam int BR_BNE  = 1;
  localparam int BR_BLT  = 2;
  localparam int BR_BGE  = 3;
  localparam int BR_BLTU = 4;
  localparam int BR_BGEU = 5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       jump;
    logic       jump_sel;
    logic [1:0] result_src;
    logic [3:0] alu;
    logic [5:0] br;
    logic       md;
    logic [2:0] md_op;
    logic       illegal;
  } ctrl_t;

  // Zero for the two reserved branch func3 codes.
  function automatic logic [5:0] br_dec(input logic [2:0] f3);
    logic [5:0] v;
    v = '0;
    case (f3)
      3'b000:  v[BR_BEQ]  = 1'b1;
      3'b001:  v[BR_BNE]  = 1'b1;
      3'b100:  v[BR_BLT]  = 1'b1;
      3'b101:  v[BR_BGE]  = 1'b1;
      3'b110:  v[BR_BLTU] = 1'b1;
      3'b111:  v[BR_BGEU] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode_comb.sv
// Pure combinational RV32I(+M) control decoder.
// Produces the E-stage control bundle, ImmSrc and the illegal flag.
module ctrl_decode_comb
  import pipe_ctrl_pkg::*;
#(
  parameter int EXT_M     = 1,
  parameter int EXT_SHIFT = 1,
  parameter int EXT_UBR   = 1
) (
  input  logic [31:0] instr,
  output logic [2:0]  imm_src,
  output ctrl_t       ctrl
);

  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       is_r;
  logic       bad;
  logic       bad_ri;
  logic [3:0] alu_ri;
  logic [5:0] br;
  logic       unused_bits;

  assign op   = instr[6:0];
  assign f3   = instr[14:12];
  assign f7   = instr[31:25];
  assign is_r = (op == OP_RT);
  assign br   = br_dec(f3);

  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    alu_ri = ALU_ADD;
    bad_ri = 1'b0;
    unique case (f3)
      3'b000: alu_ri = (is_r && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        alu_ri = ALU_SLL;
        bad_ri = (EXT_SHIFT == 0);
      end
      3'b010: alu_ri = ALU_SLT;
      3'b011: begin
        alu_ri = ALU_SLTU;
        bad_ri = (EXT_SHIFT == 0);
      end
      3'b100: begin
        alu_ri = ALU_XOR;
        bad_ri = (EXT_SHIFT == 0);
      end
      3'b101: begin
        alu_ri = f7[5] ? ALU_SRA : ALU_SRL;
        bad_ri = (EXT_SHIFT == 0);
      end
      3'b110: alu_ri = ALU_OR;
      3'b111: alu_ri = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    bad     = 1'b0;
    unique case (1'b1)
      (op == OP_LW): begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      (op == OP_SW): begin
        imm_src        = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      (op == OP_RT): begin
        ctrl.reg_write = 1'b1;
        if (f7 == F7_M) begin
          bad             = (EXT_M == 0);
          ctrl.result_src = RES_MD;
          ctrl.md         = 1'b1;
          ctrl.md_op      = f3;
        end else begin
          bad      = bad_ri;
          ctrl.alu = alu_ri;
        end
      end
      (op == OP_IT): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu       = alu_ri;
        bad            = bad_ri;
      end
      (op == OP_BT): begin
        imm_src  = IMM_B;
        ctrl.alu = ALU_SUB;
        ctrl.br  = br;
        bad      = (br == '0) ||
                   (f3[2:1] == 2'b11 && EXT_UBR == 0);
      end
      (op == OP_JAL): begin
        imm_src         = IMM_J;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      (op == OP_JALR): begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.jump_sel   = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      (op == OP_LUI): begin
        imm_src        = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu       = ALU_PASSB;
      end
      default: bad = 1'b1;
    endcase
    // Illegal words carry no side effects, only the flag.
    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      imm_src      = IMM_I;
    end
  end

endmodule

// File: rtl/pipe_ctrl_decode.sv
// D-stage decode into the ID/EX register with stall/flush,
// mul/div occupancy counter and illegal-opcode halt FSM.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int ALU_W     = 4,
  parameter int EXT_M     = 1,
  parameter int EXT_SHIFT = 1,
  parameter int EXT_UBR   = 1,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic             stall_e,
  input  logic             flush_e,
  output logic [2:0]       imm_src_d,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic             alu_src_e,
  output logic             jump_e,
  output logic             jump_sel_e,
  output logic [1:0]       result_src_e,
  output logic [ALU_W-1:0] alu_control_e,
  output logic [5:0]       br_e,
  output logic             md_start_e,
  output logic [2:0]       md_op_e,
  output logic             stall_req,
  output logic             illegal_e,
  output logic             halted
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int DW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } halt_e;

  ctrl_t          dec;
  ctrl_t          e_q;
  logic [2:0]     imm_src;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  lat_m1;
  halt_e          state;
  halt_e          state_nxt;
  logic [DW-1:0]  dcnt;
  logic [DW-1:0]  dcnt_nxt;
  logic           run;
  logic           load;
  logic           take_ill;

  ctrl_decode_comb #(
    .EXT_M     (EXT_M),
    .EXT_SHIFT (EXT_SHIFT),
    .EXT_UBR   (EXT_UBR)
  ) u_dec (
    .instr   (instr_d),
    .imm_src (imm_src),
    .ctrl    (dec)
  );

  assign run       = (state == S_RUN);
  assign stall_req = (cnt != '0);
  assign load      = run && !flush_e && !stall_e && !stall_req;
  assign take_ill  = load && valid_d && dec.illegal;
  assign lat_m1    = dec.md_op[2] ? CW'(DIV_LAT - 1)
                                  : CW'(MUL_LAT - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q <= '0;
      cnt <= '0;
    end else if (flush_e || !run) begin
      e_q <= '0;
      cnt <= '0;
    end else if (stall_e || stall_req) begin
      // Hold the bundle but never re-issue the mul/div start.
      e_q.md <= 1'b0;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end else begin
      e_q <= valid_d ? dec : '0;
      cnt <= (valid_d && dec.md) ? lat_m1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    unique case (state)
      S_RUN: begin
        if (take_ill) begin
          state_nxt = (DRAIN_CYC == 0) ? S_HALTED : S_DRAIN;
          dcnt_nxt  = '0;
        end
      end
      S_DRAIN: begin
        if (dcnt == DW'(DRAIN_CYC - 1)) state_nxt = S_HALTED;
        else dcnt_nxt = dcnt + DW'(1);
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  assign imm_src_d     = imm_src;
  assign reg_write_e   = e_q.reg_write;
  assign mem_write_e   = e_q.mem_write;
  assign alu_src_e     = e_q.alu_src;
  assign jump_e        = e_q.jump;
  assign jump_sel_e    = e_q.jump_sel;
  assign result_src_e  = e_q.result_src;
  assign alu_control_e = ALU_W'(e_q.alu);
  assign br_e          = e_q.br;
  assign md_start_e    = e_q.md;
  assign md_op_e       = e_q.md_op;
  assign illegal_e     = e_q.illegal;
  assign halted        = (state == S_HALTED);

endmodule

// File: tb/tb_pipe_ctrl_decode.sv
// Bench for pipe_ctrl_decode: directed test-plan cases plus random
// instruction streams against a mnemonic-level reference model.
module tb_pipe_ctrl_decode;

  localparam int DRAIN = 3;
  localparam int MULL  = 3;
  localparam int DIVL  = 8;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4022D293;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3;
  localparam logic [31:0] I_BLTU = 32'h0020E063;
  localparam logic [31:0] I_ILL  = 32'h0000000B;

  localparam int ALU_TAB [8] = '{0, 8, 5, 6, 7, 9, 3, 2};
  localparam int BR_BIT  [8] = '{0, 1, -1, -1, 2, 3, 4, 5};

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       as;
    logic       j;
    logic       js;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [5:0] br;
    logic       mds;
    logic [2:0] mdo;
    logic       ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = '0;
  logic        valid_d = 1'b0;
  logic        stall_e = 1'b0;
  logic        flush_e = 1'b0;

  logic [2:0] imm_src_d;
  logic       reg_write_e, mem_write_e, alu_src_e, jump_e, jump_sel_e;
  logic [1:0] result_src_e;
  logic [3:0] alu_control_e;
  logic [5:0] br_e;
  logic       md_start_e;
  logic [2:0] md_op_e;
  logic       stall_req, illegal_e, halted;

  logic [2:0] nu_imm;
  logic       nu_rw, nu_mw, nu_as, nu_j, nu_js;
  logic [1:0] nu_rs;
  logic [3:0] nu_alu;
  logic [5:0] nu_br;
  logic       nu_mds;
  logic [2:0] nu_mdo;
  logic       nu_stall, nu_ill, nu_halted;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t e_m = '0;
  int   md_left = 0;
  int   mode = 0;
  int   drain_left = 0;

  always #5 clk = ~clk;

  pipe_ctrl_decode dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_d       (instr_d),
    .valid_d       (valid_d),
    .stall_e       (stall_e),
    .flush_e       (flush_e),
    .imm_src_d     (imm_src_d),
    .reg_write_e   (reg_write_e),
    .mem_write_e   (mem_write_e),
    .alu_src_e     (alu_src_e),
    .jump_e        (jump_e),
    .jump_sel_e    (jump_sel_e),
    .result_src_e  (result_src_e),
    .alu_control_e (alu_control_e),
    .br_e          (br_e),
    .md_start_e    (md_start_e),
    .md_op_e       (md_op_e),
    .stall_req     (stall_req),
    .illegal_e     (illegal_e),
    .halted        (halted)
  );

  pipe_ctrl_decode #(.EXT_UBR(0)) dut_nu (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_d       (instr_d),
    .valid_d       (valid_d),
    .stall_e       (stall_e),
    .flush_e       (flush_e),
    .imm_src_d     (nu_imm),
    .reg_write_e   (nu_rw),
    .mem_write_e   (nu_mw),
    .alu_src_e     (nu_as),
    .jump_e        (nu_j),
    .jump_sel_e    (nu_js),
    .result_src_e  (nu_rs),
    .alu_control_e (nu_alu),
    .br_e          (nu_br),
    .md_start_e    (nu_mds),
    .md_op_e       (nu_mdo),
    .stall_req     (nu_stall),
    .illegal_e     (nu_ill),
    .halted        (nu_halted)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t got_e();
    return {reg_write_e, mem_write_e, alu_src_e, jump_e, jump_sel_e,
            result_src_e, alu_control_e, br_e, md_start_e, md_op_e,
            illegal_e};
  endfunction

  function automatic exp_t got_nu();
    return {nu_rw, nu_mw, nu_as, nu_j, nu_js, nu_rs, nu_alu, nu_br,
            nu_mds, nu_mdo, nu_ill};
  endfunction

  // Reference decode by mnemonic class.
  function automatic exp_t ref_dec(input logic [31:0] ins,
                                   output logic [2:0] imm);
    exp_t r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit bad;
    r = '0; imm = 3'd0; bad = 0;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    if (op == 7'h03) begin
      r.rw = 1; r.as = 1; r.rs = 2'd1;
    end else if (op == 7'h23) begin
      r.mw = 1; r.as = 1; imm = 3'd1;
    end else if (op == 7'h33 && f7 == 7'h01) begin
      r.rw = 1; r.rs = 2'd3; r.mds = 1; r.mdo = f3;
    end else if (op == 7'h33 || op == 7'h13) begin
      r.rw = 1; r.as = (op == 7'h13);
      r.alu = 4'(ALU_TAB[f3]);
      if (f3 == 3'd0 && op == 7'h33 && f7 == 7'h20) r.alu = 4'd1;
      if (f3 == 3'd5 && f7[5]) r.alu = 4'd10;
    end else if (op == 7'h63) begin
      imm = 3'd2; r.alu = 4'd1;
      if (BR_BIT[f3] < 0) bad = 1;
      else r.br[BR_BIT[f3]] = 1'b1;
    end else if (op == 7'h6F) begin
      r.rw = 1; r.j = 1; r.rs = 2'd2; imm = 3'd3;
    end else if (op == 7'h67) begin
      r.rw = 1; r.as = 1; r.j = 1; r.js = 1; r.rs = 2'd2;
    end else if (op == 7'h37) begin
      r.rw = 1; r.as = 1; r.alu = 4'd4; imm = 3'd4;
    end else bad = 1;
    if (bad) begin
      r = '0; r.ill = 1; imm = 3'd0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [2:0]  f3;
    int k, bi;
    r  = $urandom;
    f3 = 3'($urandom_range(0, 7));
    k  = $urandom_range(0, 9);
    r[14:12] = f3;
    case (k)
      0, 9: begin
        r[6:0] = 7'h33;
        r[31:25] = ((f3 == 3'd0 || f3 == 3'd5) &&
                    $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      4: begin
        bi = $urandom_range(0, 5);
        r[6:0] = 7'h63;
        r[14:12] = (bi < 2) ? 3'(bi) : 3'(bi + 2);
      end
      5: r[6:0] = 7'h6F;
      6: begin
        r[6:0] = 7'h67; r[14:12] = 3'd0;
      end
      7: r[6:0] = 7'h37;
      default: begin
        r[6:0] = 7'h33; r[31:25] = 7'h01;
      end
    endcase
    return r;
  endfunction

  // One clock: drive D, check ImmSrc, advance the model, check E.
  task automatic cyc(input bit rst, input logic [31:0] ins, input bit v,
                     input bit st, input bit fl);
    exp_t d;
    logic [2:0] im;
    int old_mode;
    rst_n = rst; instr_d = ins; valid_d = v; stall_e = st; flush_e = fl;
    #1;
    d = ref_dec(ins, im);
    check("imm_src_d", 32'(imm_src_d), 32'(im));
    old_mode = mode;
    if (!rst) begin
      e_m = '0; md_left = 0; mode = 0; drain_left = 0;
    end else begin
      if (fl || mode != 0) begin
        e_m = '0; md_left = 0;
      end else if (st || md_left > 0) begin
        e_m.mds = 1'b0;
        if (md_left > 0) md_left--;
      end else begin
        e_m = v ? d : '0;
        md_left = (v && d.mds) ? (d.mdo[2] ? DIVL : MULL) - 1 : 0;
        if (v && d.ill) begin
          mode = 1; drain_left = DRAIN;
        end
      end
      if (old_mode == 1) begin
        drain_left--;
        if (drain_left == 0) mode = 2;
      end
    end
    @(posedge clk); #1;
    check("e_bundle", 32'(got_e()), 32'(e_m));
    check("stall_req", 32'(stall_req), 32'(md_left > 0));
    check("halted", 32'(halted), 32'(mode == 2));
  endtask

  initial begin
    int n;
    int starts;

    cyc(0, I_ADD, 1, 0, 0);
    cyc(0, I_ADD, 1, 0, 0);
    check("rst_bundle", 32'(got_e()), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    cyc(1, I_ADD, 1, 0, 0);
    check("add_rw", 32'(reg_write_e), 32'd1);
    check("add_alu", 32'(alu_control_e), 32'd0);
    check("add_res", 32'(result_src_e), 32'd0);
    check("add_alusrc", 32'(alu_src_e), 32'd0);
    check("add_br", 32'(br_e), 32'd0);

    cyc(1, I_SUB, 1, 0, 0);
    check("sub_alu", 32'(alu_control_e), 32'd1);
    rst_n = 1; instr_d = I_SRAI; #1;
    check("srai_imm", 32'(imm_src_d), 32'd0);
    cyc(1, I_SRAI, 1, 0, 0);
    check("srai_alu", 32'(alu_control_e), 32'd10);
    check("srai_alusrc", 32'(alu_src_e), 32'd1);

    cyc(1, I_MUL, 1, 0, 0);
    check("mul_start", 32'(md_start_e), 32'd1);
    check("mul_stall0", 32'(stall_req), 32'd1);
    cyc(1, I_ADD, 1, 0, 0);
    check("mul_start1", 32'(md_start_e), 32'd0);
    check("mul_stall1", 32'(stall_req), 32'd1);
    cyc(1, I_ADD, 1, 0, 0);
    check("mul_stall2", 32'(stall_req), 32'd0);
    check("mul_res", 32'(result_src_e), 32'd3);
    cyc(1, I_ADD, 1, 0, 0);
    check("mul_next", 32'(result_src_e), 32'd0);

    cyc(1, I_DIV, 1, 0, 0);
    n = int'(stall_req);
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, I_ADD, 1, 0, 0);
      n += int'(stall_req);
      starts += int'(md_start_e);
    end
    check("div_stalls", 32'(n), 32'd7);
    check("div_restart", 32'(starts), 32'd0);

    cyc(1, I_DIV, 1, 0, 0);
    cyc(1, I_ADD, 1, 0, 0);
    cyc(1, I_ADD, 1, 0, 1);
    check("flush_stall", 32'(stall_req), 32'd0);
    check("flush_bubble", 32'(got_e()), 32'd0);
    cyc(1, I_ADD, 1, 0, 0);
    check("flush_start", 32'(md_start_e), 32'd0);

    cyc(1, I_BLTU, 1, 0, 0);
    check("bltu_br", 32'(br_e), 32'h10);
    check("bltu_imm", 32'(imm_src_d), 32'd2);
    check("nu_ill", 32'(got_nu()), 32'd1);
    check("nu_imm", 32'(nu_imm), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, I_ADD, 1, 1, 0);
      check("bltu_hold", 32'(br_e), 32'h10);
    end
    check("nu_halted", 32'(nu_halted), 32'd1);
    check("nu_stall", 32'(nu_stall), 32'd0);

    for (int i = 0; i < 1500; i++)
      cyc(1, rand_ins(), $urandom_range(0, 99) < 85,
          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);

    for (int i = 0; i < 10; i++) cyc(1, I_ADD, 1, 0, 0);
    cyc(1, I_ILL, 1, 0, 0);
    check("ill_e", 32'(illegal_e), 32'd1);
    cyc(1, I_ADD, 1, 0, 0);
    check("ill_once", 32'(illegal_e), 32'd0);
    check("drain1", 32'(halted), 32'd0);
    cyc(1, I_ADD, 1, 0, 0);
    check("drain2", 32'(halted), 32'd0);
    cyc(1, I_ADD, 1, 0, 0);
    check("halt_rise", 32'(halted), 32'd1);
    cyc(1, I_ADD, 1, 0, 0);
    check("halt_bubble", 32'(got_e()), 32'd0);
    cyc(0, I_ADD, 1, 0, 0);
    check("halt_clr", 32'(halted), 32'd0);
    cyc(1, I_ADD, 1, 0, 0);
    check("post_rst_add", 32'(reg_write_e), 32'd1);

    cyc(1, I_DIV, 1, 0, 0);
    cyc(1, I_ADD, 1, 0, 0);
    cyc(0, I_ADD, 1, 0, 0);
    check("rst_midcount", 32'(stall_req), 32'd0);
    cyc(1, I_ILL, 1, 0, 0);
    cyc(1, I_ADD, 1, 0, 0);
    cyc(0, I_ADD, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, I_ADD, 1, 0, 0);
    check("rst_drain", 32'(halted), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
